// File: rtl/seg7_scan_driver.sv
// Four-digit MM.SS multiplexed common-anode 7-segment driver.
// Minute/second counts are converted to BCD by a sequential double-dabble FSM once per scan frame.
module seg7_scan_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter int DIV_W       = 17
) (
   input  logic       clk_100M,
   input  logic       reset,
   input  logic [5:0] min_in,
   input  logic [5:0] sec_in,
   input  logic       blank,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       conv_busy
);

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       idx;
   logic             term_cnt, frame_end;
   logic [3:0][3:0]  digit;
   logic [13:0]      min_sr, sec_sr;
   logic [2:0]       iter;
   logic             start_pend;
   logic             capture, shift, commit;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // One double-dabble iteration on {tens, ones, binary}.
   function automatic logic [13:0] dabble_step(input logic [13:0] v);
      logic [3:0] t, o;
      t = v[13:10];
      o = v[9:6];
      if (t >= 4'd5) t = t + 4'd3;
      if (o >= 4'd5) o = o + 4'd3;
      return {t[2:0], o, v[5:0], 1'b0};
   endfunction

   assign term_cnt  = (div_cnt == DIV_W'(REFRESH_DIV - 1));
   assign frame_end = term_cnt && (idx == 2'd3);
   assign conv_busy = (state == CONV) || (state == COMMIT);

   always_ff @(posedge clk_100M) begin
      if (!reset) begin
         div_cnt <= '0;
         idx     <= 2'd0;
      end else if (term_cnt) begin
         div_cnt <= '0;
         idx     <= idx + 2'd1;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk_100M) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      shift     = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (frame_end || start_pend) begin
               capture   = 1'b1;
               state_nxt = CONV;
            end
         end
         CONV: begin
            shift = 1'b1;
            if (iter == 3'd5) state_nxt = COMMIT;
         end
         COMMIT: begin
            commit    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_100M) begin
      if (!reset) begin
         start_pend <= 1'b1;
         iter       <= 3'd0;
         digit      <= '0;
      end else begin
         if (capture) begin
            start_pend <= 1'b0;
            iter       <= 3'd0;
         end else if (shift) begin
            iter <= iter + 3'd1;
         end
         // Display digits change only here, so a frame never shows a half-converted value.
         if (commit) begin
            digit[3] <= min_sr[13:10];
            digit[2] <= min_sr[9:6];
            digit[1] <= sec_sr[13:10];
            digit[0] <= sec_sr[9:6];
         end
      end
   end

   always_ff @(posedge clk_100M) begin
      if (capture) begin
         min_sr <= {8'd0, min_in};
         sec_sr <= {8'd0, sec_in};
      end else if (shift) begin
         min_sr <= dabble_step(min_sr);
         sec_sr <= dabble_step(sec_sr);
      end
   end

   always_ff @(posedge clk_100M) begin
      if (!reset) begin
         an  <= 4'hF;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= blank ? 4'hF : ~(4'b0001 << idx);
         seg <= blank ? 7'h7F : seg_decode(digit[idx]);
         dp  <= (idx == 2'd2 && !blank) ? 1'b0 : 1'b1;
      end
   end

endmodule
